// File: rtl/axi4_lite_cmd_sequencer.sv
// Host command FIFO plus a one-at-a-time issuer for the AXI4-Lite master top.
// Build option: AXI_CMD_WR_ACK_EN adds a response strobe when a write's gap expires.
module axi4_lite_cmd_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS    = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int WR_GAP     = 8,
    parameter int RD_TIMEOUT = 64
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDRESS-1:0]    cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  read_s,
    output logic                  write_s,
    output logic [ADDRESS-1:0]    address,
    output logic [DATA_WIDTH-1:0] W_data,
    input  logic [DATA_WIDTH-1:0] read_data_out,
    input  logic                  read_valid_out,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam int CMAX = (WR_GAP > RD_TIMEOUT) ? WR_GAP : RD_TIMEOUT;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] RD_LAST = CW'(RD_TIMEOUT - 1);
    localparam logic [CW-1:0] WR_LAST = CW'(WR_GAP - 1);

    typedef struct packed {
        logic                  wr;
        logic [ADDRESS-1:0]    addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, WAIT_RD, WAIT_WR} state_t;

    cmd_t          mem [FIFO_DEPTH];
    cmd_t          head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push;
    state_t        state;
    logic [CW-1:0] cnt;

    // Extra pointer bit separates full (MSBs differ) from empty (all equal).
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{wr: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) wr_ptr <= '0;
        else if (push) wr_ptr <= wr_ptr + 1'b1;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_ptr    <= '0;
            read_s    <= 1'b0;
            write_s   <= 1'b0;
            address   <= '0;
            W_data    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            read_s    <= 1'b0;
            write_s   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= (state != IDLE) || !empty;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        rd_ptr  <= rd_ptr + 1'b1;
                        address <= head.addr;
                        W_data  <= head.wr ? head.wdata : '0;
                        cnt     <= '0;
                        if (head.wr) begin
                            write_s <= 1'b1;
                            state   <= WAIT_WR;
                        end else begin
                            read_s  <= 1'b1;
                            state   <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    // Valid data takes priority over a timeout landing on the same edge.
                    if (read_valid_out) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= read_data_out;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else if (cnt == RD_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_WR: begin
                    if (cnt == WR_LAST) begin
`ifdef AXI_CMD_WR_ACK_EN
                        rsp_valid <= 1'b1;
`else
                        rsp_valid <= 1'b0;
`endif
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_lite_cmd_sequencer.sv
// Randomized bench for axi4_lite_cmd_sequencer against a transaction-level
// schedule model (command queue, per-edge expected starts/responses, memory).
module tb_axi4_lite_cmd_sequencer;
    localparam int DW = 32, AWD = 32, DEPTH = 4, WG = 8, RT = 64;

    logic ACLK = 1'b0, ARESET = 1'b1;
    logic cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [AWD-1:0] cmd_addr = '0;
    logic [DW-1:0]  cmd_wdata = '0;
    logic read_s, write_s, cmd_ready, rsp_valid, rsp_err, busy;
    logic [AWD-1:0] address;
    logic [DW-1:0]  W_data, rsp_data;
    logic [DW-1:0]  read_data_out = '0;
    logic read_valid_out = 1'b0;

    axi4_lite_cmd_sequencer #(.DATA_WIDTH(DW), .ADDRESS(AWD), .FIFO_DEPTH(DEPTH),
                              .WR_GAP(WG), .RD_TIMEOUT(RT)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .read_s(read_s), .write_s(write_s), .address(address), .W_data(W_data),
        .read_data_out(read_data_out), .read_valid_out(read_valid_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] wdata; } cmd_s;
    typedef struct { logic [31:0] data; bit err; } rsp_s;

    cmd_s        q[$];
    cmd_s        inj_q[$];
    cmd_s        exp_start[int];
    rsp_s        exp_rsp[int];
    logic [31:0] rv_at[int];
    logic [31:0] mem[logic [31:0]];

    int   total = 0, bad = 0;
    int   cyc = 0, busy_until = 0;
    bit   busy_state = 0, exp_busy = 0;
    bit   have_cmd = 0, rnd_en = 0;
    int   rnd_pct = 40;
    int   force_lat = -1;
    bit   force_data_en = 0;
    logic [31:0] force_data = '0;
    logic [31:0] last_addr = '0, last_wd = '0;
    cmd_s cur;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Schedule everything that follows from the inputs seen at edge cyc.
    task automatic model_step();
        int n_pre, lat;
        cmd_s h;
        logic [31:0] d;
        n_pre = q.size();
        if (n_pre > 0 && cyc >= busy_until) begin
            h = q.pop_front();
            exp_start[cyc] = h;
            if (h.wr) begin
                mem[h.addr] = h.wdata;
                busy_until  = cyc + WG + 1;
`ifdef AXI_CMD_WR_ACK_EN
                exp_rsp[cyc + WG] = '{32'h0, 1'b0};
`endif
                if ($urandom_range(1) == 1) rv_at[cyc + 1] = $urandom;
            end else begin
                if (force_lat >= 0) lat = force_lat;
                else begin
                    int r = $urandom_range(99);
                    lat = (r < 20) ? RT : (r < 35) ? 0 : $urandom_range(1, 12);
                end
                if (lat == 0) begin
                    exp_rsp[cyc + RT] = '{32'h0, 1'b1};
                    busy_until = cyc + RT + 1;
                end else begin
                    d = force_data_en ? force_data : (mem.exists(h.addr) ? mem[h.addr] : ~h.addr);
                    rv_at[cyc + lat]   = d;
                    exp_rsp[cyc + lat] = '{d, 1'b0};
                    busy_until = cyc + lat + 1;
                    if ($urandom_range(2) == 0) rv_at[cyc + lat + 1] = $urandom;
                end
            end
        end
        if (have_cmd && n_pre < DEPTH) begin
            q.push_back(cur);
            have_cmd = 0;
        end
        exp_busy   = busy_state;
        busy_state = (cyc < busy_until - 1) || (q.size() > 0);
    endtask

    task automatic drive();
        if (!have_cmd) begin
            if (inj_q.size() > 0) begin
                cur = inj_q.pop_front();
                have_cmd = 1;
            end else if (rnd_en && $urandom_range(99) < rnd_pct) begin
                cur.wr    = $urandom_range(1);
                cur.addr  = $urandom_range(15) * 4;
                cur.wdata = $urandom;
                have_cmd  = 1;
            end
        end
        cmd_valid = have_cmd;
        cmd_write = cur.wr;
        cmd_addr  = cur.addr;
        cmd_wdata = cur.wdata;
        read_valid_out = rv_at.exists(cyc + 1);
        read_data_out  = rv_at.exists(cyc + 1) ? rv_at[cyc + 1] : 32'($urandom);
    endtask

    task automatic check();
        bit hs, hr;
        cmd_s s;
        rsp_s r;
        hs = exp_start.exists(cyc);
        hr = exp_rsp.exists(cyc);
        if (hs) begin
            s = exp_start[cyc];
            last_addr = s.addr;
            last_wd   = s.wr ? s.wdata : 32'h0;
        end else s = '{1'b0, 32'h0, 32'h0};
        chk("cmd_ready", 64'(cmd_ready), 64'(q.size() < DEPTH));
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("read_s", 64'(read_s), 64'(hs && !s.wr));
        chk("write_s", 64'(write_s), 64'(hs && s.wr));
        chk("address", 64'(address), 64'(last_addr));
        chk("W_data", 64'(W_data), 64'(last_wd));
        chk("rsp_valid", 64'(rsp_valid), 64'(hr));
        if (hr) begin
            r = exp_rsp[cyc];
            chk("rsp_data", 64'(rsp_data), 64'(r.data));
            chk("rsp_err", 64'(rsp_err), 64'(r.err));
        end
        exp_start.delete(cyc);
        exp_rsp.delete(cyc);
        if (rv_at.exists(cyc)) rv_at.delete(cyc);
    endtask

    task automatic cycle();
        @(posedge ACLK);
        cyc++;
        model_step();
        #1 drive();
        @(negedge ACLK);
        check();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        cmd_valid = 1'b0;
        read_valid_out = 1'b0;
        #1;
        chk("rst_read_s", 64'(read_s), 64'(0));
        chk("rst_write_s", 64'(write_s), 64'(0));
        chk("rst_address", 64'(address), 64'(0));
        chk("rst_W_data", 64'(W_data), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        q.delete(); inj_q.delete(); exp_start.delete(); exp_rsp.delete(); rv_at.delete();
        have_cmd = 0; busy_until = 0; busy_state = 0; exp_busy = 0;
        last_addr = '0; last_wd = '0;
        @(posedge ACLK); cyc++;
        @(posedge ACLK); cyc++;
        #1 ARESET = 1'b0;
        @(negedge ACLK);
    endtask

    initial begin
        do_reset();
        run(3);

        // write then read back through the memory-backed responder
        force_lat = 5;
        inj_q.push_back('{1'b1, 32'h10, 32'hA5A5_0001});
        inj_q.push_back('{1'b0, 32'h10, 32'h0});
        run(40);

        // stalled AXI side (timeouts) while five reads are offered
        force_lat = 0;
        for (int i = 0; i < 5; i++) inj_q.push_back('{1'b0, 32'(i * 4), 32'h0});
        run(5 * (RT + 2) + 10);

        // data arriving on the exact timeout edge
        force_lat = RT; force_data_en = 1; force_data = 32'h1234;
        inj_q.push_back('{1'b0, 32'h20, 32'h0});
        run(RT + 10);
        force_data_en = 0;

        // random traffic
        force_lat = -1; rnd_en = 1; rnd_pct = 40;
        run(2000);
        rnd_en = 0;
        run(5 * (RT + 2) + 10);

        // reset while a read waits with two more queued
        force_lat = 0;
        for (int i = 0; i < 3; i++) inj_q.push_back('{1'b0, 32'(32'h40 + i * 4), 32'h0});
        run(4);
        chk("pre_rst_queued", 64'(q.size()), 64'(2));
        do_reset();
        run(RT + 20);

        // more random traffic with heavier offered load
        force_lat = -1; rnd_en = 1; rnd_pct = 80;
        run(1000);
        rnd_en = 0;
        run(5 * (RT + 2) + 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
